// File: rtl/accum_sched_if.sv
// Handshake/data bundle between two requesters and the accumulating scheduler.
// The master side drives the requests and clear. The slave side returns ready, grant and the sums.
interface accum_sched_if #(
  parameter int unsigned BUS_WIDTH = 4
);
  logic                 i_valid0;
  logic                 i_valid1;
  logic [BUS_WIDTH-1:0] i_data0;
  logic [BUS_WIDTH-1:0] i_data1;
  logic                 o_ready0;
  logic                 o_ready1;
  logic                 i_clear;
  logic [BUS_WIDTH-1:0] o_dout0;
  logic [BUS_WIDTH-1:0] o_dout1;
  logic [1:0]           o_grant;
  logic                 o_busy;

  modport master (
    output i_valid0, i_valid1, i_data0, i_data1, i_clear,
    input  o_ready0, o_ready1, o_dout0, o_dout1, o_grant, o_busy
  );

  modport slave (
    input  i_valid0, i_valid1, i_data0, i_data1, i_clear,
    output o_ready0, o_ready1, o_dout0, o_dout1, o_grant, o_busy
  );
endinterface

// File: rtl/accum_sched.sv
// Two-requester burst arbiter with one bubble cycle between grants.
// Each requester feeds its own wrapping accumulator, and the accumulators share a synchronous clear.
module accum_sched #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic         i_clk,
  input  logic         i_arst_n,
  accum_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t               state_q;
  logic                 last_grant_q;
  logic [3:0]           beat_cnt_q;
  logic [BUS_WIDTH-1:0] acc0_q, acc0_d;
  logic [BUS_WIDTH-1:0] acc1_q, acc1_d;
  logic                 accept0, accept1;

  // Handshake outputs decode registered state only; valid never reaches ready combinationally.
  assign bus.o_ready0 = (state_q == GNT0);
  assign bus.o_ready1 = (state_q == GNT1);
  assign bus.o_grant  = {state_q == GNT1, state_q == GNT0};
  assign bus.o_busy   = (state_q != IDLE);
  assign bus.o_dout0  = acc0_q;
  assign bus.o_dout1  = acc1_q;

  assign accept0 = bus.i_valid0 && (state_q == GNT0);
  assign accept1 = bus.i_valid1 && (state_q == GNT1);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (bus.i_valid0 && (!bus.i_valid1 || last_grant_q)) begin
            state_q      <= GNT0;
            last_grant_q <= 1'b0;
          end else if (bus.i_valid1) begin
            state_q      <= GNT1;
            last_grant_q <= 1'b1;
          end
        end
        GNT0: begin
          if (!accept0 || beat_cnt_q == LAST_BEAT) begin
            state_q <= IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end
        end
        GNT1: begin
          if (!accept1 || beat_cnt_q == LAST_BEAT) begin
            state_q <= IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A clear on an accepting cycle leaves only the new beat in that accumulator.
  always_comb begin
    acc0_d = bus.i_clear ? '0 : acc0_q;
    acc1_d = bus.i_clear ? '0 : acc1_q;
    if (accept0) acc0_d = acc0_d + bus.i_data0;
    if (accept1) acc1_d = acc1_d + bus.i_data1;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      acc0_q <= '0;
      acc1_q <= '0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
    end
  end

endmodule

// File: tb/tb_accum_sched.sv
// Directed bench for accum_sched with hand-computed expectations.
// The bench uses BUS_WIDTH=4 and BURST_LEN=4.
module tb_accum_sched;

  logic i_clk;
  logic i_arst_n;
  int   n_checks;
  int   n_fail;

  accum_sched_if #(.BUS_WIDTH(4)) bus ();

  accum_sched #(.BUS_WIDTH(4), .BURST_LEN(4)) dut (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .bus      (bus.slave)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    i_arst_n = 1'b0;
    bus.i_valid0 = 1'b0; bus.i_valid1 = 1'b0;
    bus.i_data0  = '0;   bus.i_data1  = '0;
    bus.i_clear  = 1'b0;
    #12;
    chk("rst_grant", 32'(bus.o_grant), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_ready", 32'({bus.o_ready1, bus.o_ready0}), 0);
    chk("rst_dout0", 32'(bus.o_dout0), 0);
    chk("rst_dout1", 32'(bus.o_dout1), 0);
    i_arst_n = 1'b1;

    // Single requester, six beats: a four-beat burst, a bubble, then two more beats.
    bus.i_valid0 = 1'b1; bus.i_data0 = 4'd3;
    tick();
    chk("t1_grant0", 32'(bus.o_grant), 1);
    chk("t1_ready0", 32'(bus.o_ready0), 1);
    chk("t1_busy", 32'(bus.o_busy), 1);
    ticks(3);
    chk("t1_dout0_3beats", 32'(bus.o_dout0), 9);
    tick();
    chk("t1_burst_end", 32'(bus.o_grant), 0);
    chk("t1_busy_bubble", 32'(bus.o_busy), 0);
    chk("t1_dout0_12", 32'(bus.o_dout0), 12);
    tick();
    chk("t1_regrant0", 32'(bus.o_grant), 1);
    ticks(2);
    chk("t1_dout0_wrap", 32'(bus.o_dout0), 2);
    bus.i_valid0 = 1'b0;
    tick();
    chk("t1_drop_idle", 32'(bus.o_grant), 0);
    chk("t1_dout0_hold", 32'(bus.o_dout0), 2);

    // A clear with no accepted beat zeroes both accumulators.
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    chk("clr_dout0", 32'(bus.o_dout0), 0);
    chk("clr_dout1", 32'(bus.o_dout1), 0);
    chk("clr_grant", 32'(bus.o_grant), 0);

    // Requester 1 sends two beats and drops valid; its next grant gets a full four-beat burst.
    bus.i_valid1 = 1'b1; bus.i_data1 = 4'd5;
    tick();
    chk("t3_grant1", 32'(bus.o_grant), 2);
    ticks(2);
    chk("t3_dout1_10", 32'(bus.o_dout1), 10);
    chk("t3_still_gnt1", 32'(bus.o_grant), 2);
    bus.i_valid1 = 1'b0;
    tick();
    chk("t3_drop_idle", 32'(bus.o_grant), 0);
    chk("t3_dout1_hold", 32'(bus.o_dout1), 10);
    bus.i_valid1 = 1'b1; bus.i_data1 = 4'd1;
    tick();
    chk("t3_regrant1", 32'(bus.o_grant), 2);
    ticks(3);
    chk("t3_cnt_restart", 32'(bus.o_grant), 2);
    chk("t3_dout1_13", 32'(bus.o_dout1), 13);
    tick();
    chk("t3_full_burst_end", 32'(bus.o_grant), 0);
    chk("t3_dout1_14", 32'(bus.o_dout1), 14);
    bus.i_valid1 = 1'b0;

    // A clear on an accepting beat keeps only that beat and zeroes the other accumulator.
    bus.i_valid0 = 1'b1; bus.i_data0 = 4'd7;
    tick();
    chk("t4_grant0", 32'(bus.o_grant), 1);
    ticks(2);
    chk("t4_dout0_14", 32'(bus.o_dout0), 14);
    bus.i_data0 = 4'd4; bus.i_clear = 1'b1;
    tick();
    chk("t4_clr_beat_dout0", 32'(bus.o_dout0), 4);
    chk("t4_clr_beat_dout1", 32'(bus.o_dout1), 0);
    chk("t4_clr_keeps_fsm", 32'(bus.o_grant), 1);
    bus.i_clear = 1'b0;
    bus.i_valid0 = 1'b0;
    tick();
    chk("t4_idle", 32'(bus.o_grant), 0);
    bus.i_valid0 = 1'b1; bus.i_data0 = 4'd5;
    tick();
    chk("t4_grant0_again", 32'(bus.o_grant), 1);
    ticks(2);
    chk("t4_dout0_14b", 32'(bus.o_dout0), 14);
    bus.i_data0 = 4'd4;
    tick();
    chk("t4_wrap_dout0", 32'(bus.o_dout0), 2);
    bus.i_valid0 = 1'b0;
    tick();
    chk("t4_idle_end", 32'(bus.o_grant), 0);

    // Reset is asserted mid-GNT1 between clock edges.
    bus.i_valid1 = 1'b1; bus.i_data1 = 4'd5;
    tick();
    chk("t5_grant1", 32'(bus.o_grant), 2);
    tick();
    chk("t5_dout1_5", 32'(bus.o_dout1), 5);
    #2;
    i_arst_n = 1'b0;
    #1;
    chk("t5_rst_grant", 32'(bus.o_grant), 0);
    chk("t5_rst_ready1", 32'(bus.o_ready1), 0);
    chk("t5_rst_busy", 32'(bus.o_busy), 0);
    chk("t5_rst_dout0", 32'(bus.o_dout0), 0);
    chk("t5_rst_dout1", 32'(bus.o_dout1), 0);
    tick();
    chk("t5_no_beat_in_rst", 32'(bus.o_dout1), 0);
    @(negedge i_clk);
    #1;
    i_arst_n = 1'b1;

    // Both requesters are valid: grants alternate 0,1,0,1 with a bubble between grants.
    bus.i_valid0 = 1'b1; bus.i_data0 = 4'd1;
    bus.i_valid1 = 1'b1; bus.i_data1 = 4'd2;
    tick();
    chk("t6_first_grant0", 32'(bus.o_grant), 1);
    ticks(4);
    chk("t6_bubble1", 32'(bus.o_grant), 0);
    chk("t6_dout0_4", 32'(bus.o_dout0), 4);
    tick();
    chk("t6_grant1", 32'(bus.o_grant), 2);
    ticks(4);
    chk("t6_bubble2", 32'(bus.o_grant), 0);
    chk("t6_dout1_8", 32'(bus.o_dout1), 8);
    tick();
    chk("t6_grant0_again", 32'(bus.o_grant), 1);
    ticks(4);
    chk("t6_bubble3", 32'(bus.o_grant), 0);
    chk("t6_dout0_8", 32'(bus.o_dout0), 8);
    chk("t6_dout1_8b", 32'(bus.o_dout1), 8);
    tick();
    chk("t6_grant1_again", 32'(bus.o_grant), 2);
    ticks(4);
    chk("t6_bubble4", 32'(bus.o_grant), 0);
    chk("t6_dout1_wrap0", 32'(bus.o_dout1), 0);
    chk("t6_dout0_final", 32'(bus.o_dout0), 8);
    bus.i_valid0 = 1'b0; bus.i_valid1 = 1'b0;
    tick();
    chk("t6_idle_final", 32'(bus.o_grant), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
